// File: rtl/lorenz_pkg.sv
// Shared types and fixed-point constants for the Lorenz forward-Euler solver.
package lorenz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int LZ_WIDTH = 27;
    localparam int LZ_FRAC  = 20;

    localparam logic [LZ_WIDTH-1:0] FX_ONE = LZ_WIDTH'(1) << LZ_FRAC;
    localparam logic [LZ_WIDTH-1:0] FX_MAX = {1'b0, {(LZ_WIDTH-1){1'b1}}};
    localparam logic [LZ_WIDTH-1:0] FX_MIN = {1'b1, {(LZ_WIDTH-1){1'b0}}};

    // Signed overflow from the sign bits of the operands and the result.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sd);
        return (sa != sb) && (sd != sa);
    endfunction

endpackage

// File: rtl/fx_mult.sv
// Signed fixed-point multiply: full product, keep sign plus the in-range bits (floors toward -inf).
module fx_mult #(
    parameter int WIDTH = 27,
    parameter int FRAC  = 20
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);
    logic signed [2*WIDTH-1:0] full;
    logic                      unused_bits;

    assign full        = a * b;
    assign p           = {full[2*WIDTH-1], full[WIDTH-2+FRAC:FRAC]};
    assign unused_bits = ^{full[2*WIDTH-2:WIDTH-1+FRAC], full[FRAC-1:0]};
endmodule

// File: rtl/lorenz_solver.sv
// Forward-Euler Lorenz integrator with run control, step divider and overflow flag.
// Build option: define LORENZ_SAT_EN to clamp overflowing state adds instead of wrapping.
module lorenz_solver
    import lorenz_pkg::*;
#(
    parameter int WIDTH = LZ_WIDTH,
    parameter int FRAC  = LZ_FRAC,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] init_x,
    input  logic [WIDTH-1:0] init_y,
    input  logic [WIDTH-1:0] init_z,
    input  logic [WIDTH-1:0] delta,
    input  logic [WIDTH-1:0] sigma,
    input  logic [WIDTH-1:0] beta,
    input  logic [WIDTH-1:0] rho,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [DIV_W-1:0] step_limit,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] step_count,
    output logic             overflow
);
    localparam int S1 = 3;
    localparam int S2 = 4;

    state_t           state;
    logic [WIDTH-1:0] dt_q, sigma_q, beta_q, rd_q;
    logic [DIV_W-1:0] div_q, limit_q, div_cnt, step_nx;
    logic             tick;

    logic [S1-1:0][WIDTH-1:0] a1, b1, p1;
    logic [S2-1:0][WIDTH-1:0] a2, b2, p2;
    logic [WIDTH-1:0] xd, xe, zd, dx, ry, ty, tz, sx, sy, sz, x_n, y_n, z_n;
    logic             o_dx, o_ry, o_ty, o_tz, o_x, o_y, o_z, ovf_any;

    // First rank: state scaled by dt (xd, xe, zd).
    assign a1[0] = y_out;  assign b1[0] = dt_q;
    assign a1[1] = x_out;  assign b1[1] = dt_q;
    assign a1[2] = z_out;  assign b1[2] = dt_q;

    assign xd = p1[0];
    assign xe = p1[1];
    assign zd = p1[2];
    assign dx = xd - xe;
    assign ry = rd_q - zd;

    // Second rank; lane 2 doubles as rho*dt during LOAD, which is constant for the run.
    assign a2[0] = sigma_q;                          assign b2[0] = dx;
    assign a2[1] = x_out;                            assign b2[1] = ry;
    assign a2[2] = (state == LOAD) ? rho   : x_out;  assign b2[2] = (state == LOAD) ? delta : xd;
    assign a2[3] = beta_q;                           assign b2[3] = zd;

    for (genvar i = 0; i < S1; i++) begin : g_mul1
        fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (.a(a1[i]), .b(b1[i]), .p(p1[i]));
    end
    for (genvar i = 0; i < S2; i++) begin : g_mul2
        fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (.a(a2[i]), .b(b2[i]), .p(p2[i]));
    end

    assign ty = p2[1] - xd;
    assign tz = p2[2] - p2[3];
    assign sx = x_out + p2[0];
    assign sy = y_out + ty;
    assign sz = z_out + tz;

    assign o_dx = sub_ovf(xd[WIDTH-1], xe[WIDTH-1], dx[WIDTH-1]);
    assign o_ry = sub_ovf(rd_q[WIDTH-1], zd[WIDTH-1], ry[WIDTH-1]);
    assign o_ty = sub_ovf(p2[1][WIDTH-1], xd[WIDTH-1], ty[WIDTH-1]);
    assign o_tz = sub_ovf(p2[2][WIDTH-1], p2[3][WIDTH-1], tz[WIDTH-1]);
    assign o_x  = add_ovf(x_out[WIDTH-1], p2[0][WIDTH-1], sx[WIDTH-1]);
    assign o_y  = add_ovf(y_out[WIDTH-1], ty[WIDTH-1], sy[WIDTH-1]);
    assign o_z  = add_ovf(z_out[WIDTH-1], tz[WIDTH-1], sz[WIDTH-1]);
    assign ovf_any = o_dx | o_ry | o_ty | o_tz | o_x | o_y | o_z;

`ifdef LORENZ_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    // Overflow only happens when both operands share a sign, so the old state's sign picks the rail.
    assign x_n = o_x ? (x_out[WIDTH-1] ? SAT_MIN : SAT_MAX) : sx;
    assign y_n = o_y ? (y_out[WIDTH-1] ? SAT_MIN : SAT_MAX) : sy;
    assign z_n = o_z ? (z_out[WIDTH-1] ? SAT_MIN : SAT_MAX) : sz;
`else
    assign x_n = sx;
    assign y_n = sy;
    assign z_n = sz;
`endif

    assign tick    = (state == RUN) && (div_cnt == div_q);
    assign step_nx = step_count + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            x_out      <= '0;
            y_out      <= '0;
            z_out      <= '0;
            dt_q       <= '0;
            sigma_q    <= '0;
            beta_q     <= '0;
            rd_q       <= '0;
            div_q      <= '0;
            limit_q    <= '0;
            div_cnt    <= '0;
            step_count <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (start && !stop) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: if (stop) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    x_out      <= init_x;
                    y_out      <= init_y;
                    z_out      <= init_z;
                    dt_q       <= delta;
                    sigma_q    <= sigma;
                    beta_q     <= beta;
                    rd_q       <= p2[2];
                    div_q      <= clk_div;
                    limit_q    <= step_limit;
                    div_cnt    <= '0;
                    step_count <= '0;
                    overflow   <= 1'b0;
                    state      <= RUN;
                end
                RUN: if (stop) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (tick) begin
                    x_out      <= x_n;
                    y_out      <= y_n;
                    z_out      <= z_n;
                    div_cnt    <= '0;
                    step_count <= step_nx;
                    out_valid  <= 1'b1;
                    overflow   <= overflow | ovf_any;
                    if (limit_q != '0 && step_nx == limit_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                DONE: if (stop) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end else if (start) begin
                    state <= LOAD;
                    done  <= 1'b0;
                    busy  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lorenz_solver.sv
// Directed bench for lorenz_solver: hand-derived vectors plus a wide-integer Euler reference.
module tb_lorenz_solver;
    import lorenz_pkg::*;

    localparam int W  = 27;
    localparam int DW = 16;

    localparam longint L_X0 = -longint'(1) << 20;
    localparam longint L_Y0 = 104857;
    localparam longint L_Z0 = 25 * (longint'(1) << 20);
    localparam longint L_DT = 4096;
    localparam longint L_SG = 10 * (longint'(1) << 20);
    localparam longint L_BT = 2796202;
    localparam longint L_RH = 28 * (longint'(1) << 20);

    logic          clk, reset_n, start, stop;
    logic [W-1:0]  init_x, init_y, init_z, delta, sigma, beta, rho;
    logic [DW-1:0] clk_div, step_limit;
    logic [W-1:0]  x_out, y_out, z_out;
    logic          out_valid, busy, done, overflow;
    logic [DW-1:0] step_count;

    int tests = 0;
    int fails = 0;

    lorenz_solver dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .init_x(init_x), .init_y(init_y), .init_z(init_z),
        .delta(delta), .sigma(sigma), .beta(beta), .rho(rho),
        .clk_div(clk_div), .step_limit(step_limit),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .out_valid(out_valid), .busy(busy), .done(done),
        .step_count(step_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wr(input longint v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return longint'(t);
    endfunction

    function automatic longint fm(input longint a, input longint b);
        return wr((a * b) >>> 20);
    endfunction

    function automatic longint sv(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model_step(inout longint x, inout longint y, inout longint z,
                              input longint dt, input longint sg, input longint bt, input longint rh);
        longint xd, xe, zd, rd, nx, ny, nz;
        xd = fm(y, dt);
        xe = fm(x, dt);
        zd = fm(z, dt);
        rd = fm(rh, dt);
        nx = wr(x + fm(sg, wr(xd - xe)));
        ny = wr(y + wr(fm(x, wr(rd - zd)) - xd));
        nz = wr(z + wr(fm(x, xd) - fm(bt, zd)));
        x = nx; y = ny; z = nz;
    endtask

    task automatic set_nominal();
        init_x = W'(L_X0); init_y = W'(L_Y0); init_z = W'(L_Z0);
        delta  = W'(L_DT); sigma  = W'(L_SG); beta   = W'(L_BT); rho = W'(L_RH);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!out_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        longint mx, my, mz, xs;
        int n, cnt;

        reset_n = 1'b0; start = 1'b0; stop = 1'b0;
        init_x = '0; init_y = '0; init_z = '0;
        delta = '0; sigma = '0; beta = '0; rho = '0;
        clk_div = '0; step_limit = '0;
        repeat (2) @(negedge clk);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_z", z_out, 0);
        chk("rst_flags", {out_valid, busy, done, overflow}, 0);
        chk("rst_cnt", step_count, 0);
        reset_n = 1'b1;

        // Single step, hand-computed values.
        set_nominal();
        clk_div = 0; step_limit = 1;
        pulse_start();
        chk("t1_load_busy", busy, 1);
        @(negedge clk);
        chk("t1_no_early_valid", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_x", sv(x_out), -1003526);
        chk("t1_y", sv(y_out), 92160);
        chk("t1_z", sv(z_out), 25940925);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_cnt", step_count, 1);
        @(negedge clk);
        chk("t1_single_pulse", out_valid, 0);
        pulse_stop();
        chk("t1_stop_done", {busy, done}, 0);

        // Divided rate: four steps, one every four cycles.
        set_nominal();
        clk_div = 3; step_limit = 4;
        mx = L_X0; my = L_Y0; mz = L_Z0;
        pulse_start();
        wait_valid(20, n);
        chk("t2_first_latency", n, 5);
        model_step(mx, my, mz, L_DT, L_SG, L_BT, L_RH);
        chk("t2_x1", sv(x_out), mx);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            wait_valid(10, n);
            chk("t2_valid", out_valid, 1);
            chk("t2_gap", n + 1, 4);
            model_step(mx, my, mz, L_DT, L_SG, L_BT, L_RH);
        end
        chk("t2_x4", sv(x_out), mx);
        chk("t2_y4", sv(y_out), my);
        chk("t2_z4", sv(z_out), mz);
        chk("t2_cnt", step_count, 4);
        chk("t2_done", done, 1);
        xs = sv(x_out);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("t2_hold_pulses", cnt, 0);
        chk("t2_hold_x", sv(x_out), xs);
        chk("t2_hold_cnt", step_count, 4);

        // Restart from DONE, then scramble every input mid-run and pulse start (ignored).
        set_nominal();
        clk_div = 1; step_limit = 10;
        mx = L_X0; my = L_Y0; mz = L_Z0;
        pulse_start();
        chk("t3_restart_busy", busy, 1);
        chk("t3_restart_done", done, 0);
        @(negedge clk);
        init_x = '0; init_y = W'(7); init_z = '0;
        delta = W'(3 * L_DT); sigma = '0; beta = W'(L_SG); rho = '0;
        clk_div = 0; step_limit = 2;
        start = 1'b1;
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                cnt++;
                model_step(mx, my, mz, L_DT, L_SG, L_BT, L_RH);
                chk("t3_x", sv(x_out), mx);
                chk("t3_y", sv(y_out), my);
                chk("t3_z", sv(z_out), mz);
            end
        end
        chk("t3_steps", cnt, 10);
        chk("t3_cnt", step_count, 10);
        chk("t3_done", done, 1);

        // Overflow on the x add, then cleared by the next start.
        set_nominal();
        init_x = FX_MAX;
        sigma = -(W'(10) * FX_ONE);
        clk_div = 0; step_limit = 1;
        pulse_start();
        wait_valid(10, n);
        chk("t4_valid", out_valid, 1);
        chk("t4_ovf", overflow, 1);
`ifdef LORENZ_SAT_EN
        chk("t4_x_sat", x_out, FX_MAX);
`else
        chk("t4_x_wrap", sv(x_out), -64491525);
`endif
        repeat (5) @(negedge clk);
        chk("t4_ovf_sticky", overflow, 1);
        set_nominal();
        pulse_start();
        @(negedge clk);
        chk("t4_ovf_clear", overflow, 0);
        wait_valid(10, n);
        chk("t4_rerun_x", sv(x_out), -1003526);
        chk("t4_rerun_ovf", overflow, 0);
        chk("t4_min_const", FX_MIN, 27'h4000000);

        // Free-run for 1000 cycles, then stop.
        pulse_stop();
        set_nominal();
        clk_div = 0; step_limit = 0;
        mx = L_X0; my = L_Y0; mz = L_Z0;
        pulse_start();
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                model_step(mx, my, mz, L_DT, L_SG, L_BT, L_RH);
            end
        end
        chk("t5_busy_running", busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t5_stop_busy", busy, 0);
        chk("t5_stop_valid", out_valid, 0);
        chk("t5_pulses", cnt, 999);
        chk("t5_cnt", step_count, cnt);
        chk("t5_x", sv(x_out), mx);
        chk("t5_z", sv(z_out), mz);
        xs = sv(x_out);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("t5_frozen_pulses", cnt, 0);
        chk("t5_frozen_x", sv(x_out), xs);

        // Asynchronous reset in the middle of a run.
        pulse_start();
        repeat (50) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_async_x", x_out, 0);
        chk("t6_async_flags", {out_valid, busy, done, overflow}, 0);
        chk("t6_async_cnt", step_count, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_x", x_out, 0);

        // start and stop together in IDLE: stop wins.
        @(negedge clk) begin start = 1'b1; stop = 1'b1; end
        @(negedge clk) begin start = 1'b0; stop = 1'b0; end
        chk("t7_busy", busy, 0);
        @(negedge clk);
        chk("t7_still_idle", {busy, done, out_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
